// File: rtl/uart_pkg.sv
// uart_pkg: constants, receiver state encoding and a constant-evaluable
// ceil(log2) used by the serial receiver and its output FIFO.
package uart_pkg;

    // Parity mode selectors for the receiver's PARITY_MODE parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Receiver states. IDLE must stay at the reset encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO.
//   clock, reset     : system clock, asynchronous active-high reset
//   push_i/push_data_i: write request and word
//   pop_i            : remove head entry (ignored when empty)
//   head_o           : head entry, combinational from storage
//   valid_o          : FIFO not empty
//   overrun_o        : push dropped because full and no simultaneous pop
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             overrun_o
);

    localparam int ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted when it coincides with a read.
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    assign rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};
    assign wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (push_ok && (wr_ptr_q[ADDR_W-1:0] == ADDR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    assign head_o    = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign valid_o   = ~empty;
    assign overrun_o = push_i & full & ~pop_ok;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled serial receiver with parity/framing checks and
// a FWFT output FIFO.
//   clock, reset   : system clock, asynchronous active-high reset
//   rxd            : serial line (idle high, asynchronous)
//   rd_en          : pop head entry, ignored when valid = 0
//   data           : head entry data bits
//   parity_error   : head entry parity mismatch
//   framing_error  : head entry had a stop bit sampled low
//   valid          : FIFO not empty
//   overrun        : one-cycle pulse when a completed frame is dropped
//   busy           : receiver not in IDLE
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 9600,
    parameter int CLOCK_HZ    = 50_000_000,
    parameter int N_BITS      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rxd,
    input  logic              rd_en,
    output logic [N_BITS-1:0] data,
    output logic              parity_error,
    output logic              framing_error,
    output logic              valid,
    output logic              overrun,
    output logic              busy
);

    localparam int DIV_RAW = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam int SC_W    = clog2(OVERSAMPLE);
    localparam int BC_W    = clog2(N_BITS);
    localparam int FW      = N_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_A     = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_B     = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  SC_C     = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(N_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // ---------------- synchroniser ----------------
    logic sync1_q;
    logic rs_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rs_q    <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rs_q    <= sync1_q;
        end
    end

    // ---------------- state registers ----------------
    rx_state_e         state_q, state_d;
    logic [N_BITS-1:0] shift_q, shift_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              armed_q, armed_d;
    logic              push_q, push_d;

    logic [DIV_W-1:0]  div_q;
    logic [SC_W-1:0]   sc_q;
    logic              samp_a_q;
    logic              samp_b_q;

    logic tick;
    logic start_entry;
    logic bit_point;
    logic maj;
    logic fe_now;

    assign tick        = (div_q == DIV_LAST);
    // Falling edge seen in IDLE: realign tick and sample counters to it.
    assign start_entry = (state_q == IDLE) && !rs_q;
    assign bit_point   = tick && (sc_q == SC_C);
    // Third vote is the live sample taken at the bit point itself.
    assign maj         = (samp_a_q & samp_b_q) | (samp_a_q & rs_q) | (samp_b_q & rs_q);
    assign fe_now      = fe_q | ~maj;

    // ---------------- tick / sample counters ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            sc_q     <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            if (start_entry || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (start_entry) begin
                sc_q <= '0;
            end else if (tick) begin
                sc_q <= (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
            end

            if (tick && (sc_q == SC_A)) begin
                samp_a_q <= rs_q;
            end
            if (tick && (sc_q == SC_B)) begin
                samp_b_q <= rs_q;
            end
        end
    end

    // ---------------- receive FSM ----------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bc_d       = bc_q;
        stop_cnt_d = stop_cnt_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        armed_d    = armed_q;
        push_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rs_q) begin
                    state_d    = START;
                    bc_d       = '0;
                    stop_cnt_d = 1'b0;
                    pe_d       = 1'b0;
                    fe_d       = 1'b0;
                end
            end

            START: begin
                if (bit_point) begin
                    state_d = maj ? IDLE : DATA;
                end
            end

            DATA: begin
                if (bit_point) begin
                    shift_d = {maj, shift_q[N_BITS-1:1]};
                    if (bc_q == BC_LAST) begin
                        bc_d    = '0;
                        state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bc_d = bc_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bit_point) begin
                    if (PARITY_MODE == PAR_ODD) begin
                        pe_d = ~(^shift_q ^ maj);
                    end else begin
                        pe_d = ^shift_q ^ maj;
                    end
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_point) begin
                    fe_d = fe_now;
                    if (stop_cnt_q == STOP_LAST) begin
                        // Leave at mid-stop for half a bit of resync margin.
                        push_d  = 1'b1;
                        armed_d = 1'b0;
                        state_d = fe_now ? WAIT_IDLE : IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                // Require the line high across a whole tick interval so a
                // held-low break yields a single frame only.
                if (!rs_q) begin
                    armed_d = 1'b0;
                end else if (tick) begin
                    if (armed_q) begin
                        state_d = IDLE;
                    end else begin
                        armed_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bc_q       <= '0;
            stop_cnt_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            armed_q    <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bc_q       <= bc_d;
            stop_cnt_q <= stop_cnt_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            armed_q    <= armed_d;
            push_q     <= push_d;
        end
    end

    // ---------------- output FIFO ----------------
    logic [FW-1:0] head;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_q),
        .push_data_i ({shift_q, pe_q, fe_q}),
        .pop_i       (rd_en),
        .head_o      (head),
        .valid_o     (valid),
        .overrun_o   (overrun)
    );

    assign data          = head[FW-1:2];
    assign parity_error  = head[1];
    assign framing_error = head[0];
    assign busy          = (state_q != IDLE);

endmodule
